// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel scan-out engine:
// scan state enum, shift phase codes and pixel colour field offsets.
package led_panel_pkg;

    typedef enum logic [1:0] {
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

endpackage

// File: rtl/led_panel_bcm_timer.sv
// BCM display-window timer: counts BASE_TIME<<plane cycles while run is high.
// Ports: clock, reset, run, plane in; done (last window cycle), oe_active out.
// LEDPANEL_BRIGHTNESS_EN adds brightness[7:0], shortening the lit part of
// the window to (window*brightness)>>8 cycles.
module led_panel_bcm_timer #(
    parameter int BASE_TIME = 8,
    parameter int BITS      = 8,
    localparam int PW       = $clog2(BITS),
    localparam int CW       = $clog2(BASE_TIME) + BITS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic [PW-1:0] plane,
`ifdef LEDPANEL_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          done,
    output logic          oe_active
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] window;

    assign window = CW'(BASE_TIME) << plane;
    assign done   = run && (cnt == window - CW'(1));

`ifdef LEDPANEL_BRIGHTNESS_EN
    logic [CW+7:0] prod;
    logic [CW-1:0] thr;

    assign prod      = (CW+8)'(window) * (CW+8)'(brightness);
    assign thr       = prod[CW+7:8];
    assign oe_active = run && (cnt < thr);
`else
    assign oe_active = run;
`endif

    // Counter idles at zero so every window starts from a clean count.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_panel_scanner.sv
// HUB75 frame-buffer reader and BCM scan-out engine.
// Ports: clock, reset, Address_b/DataOut_b (frame memory read port, 1-clk
// latency), panel_r1/g1/b1/r2/g2/b2, panel_row, panel_clk, panel_lat,
// panel_oe_n, frame_start. LEDPANEL_BRIGHTNESS_EN adds brightness[7:0].
module led_panel_scanner
    import led_panel_pkg::*;
#(
    parameter int ADDR_LINES = 10,
    parameter int DATA_LINES = 24,
    parameter int COLUMNS    = 32,
    parameter int ROW_BITS   = 4,
    parameter int BASE_TIME  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_LINES-1:0] Address_b,
    input  logic [DATA_LINES-1:0] DataOut_b,
`ifdef LEDPANEL_BRIGHTNESS_EN
    input  logic [7:0]            brightness,
`endif
    output logic                  panel_r1,
    output logic                  panel_g1,
    output logic                  panel_b1,
    output logic                  panel_r2,
    output logic                  panel_g2,
    output logic                  panel_b2,
    output logic [ROW_BITS-1:0]   panel_row,
    output logic                  panel_clk,
    output logic                  panel_lat,
    output logic                  panel_oe_n,
    output logic                  frame_start
);

    localparam int BITS = DATA_LINES / 3;
    localparam int PW   = $clog2(BITS);
    localparam int CW   = $clog2(COLUMNS);
    localparam int DW   = $clog2(DATA_LINES);

    state_t                state;
    logic [1:0]            phase;
    logic [CW-1:0]         col;
    logic [CW-1:0]         nxt_col;
    logic [ROW_BITS-1:0]   row;
    logic [ROW_BITS-1:0]   nxt_row;
    logic [PW-1:0]         plane;
    logic [PW-1:0]         nxt_plane;
    logic [DATA_LINES-1:0] upper;
    logic [DW-1:0]         ri, gi, bi;
    logic                  done;
    logic                  oe_active;

    led_panel_bcm_timer #(
        .BASE_TIME (BASE_TIME),
        .BITS      (BITS)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .run        (state == DISPLAY),
        .plane      (plane),
`ifdef LEDPANEL_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .done       (done),
        .oe_active  (oe_active)
    );

    assign ri      = DW'(R_LSB) + DW'(plane);
    assign gi      = DW'(G_LSB) + DW'(plane);
    assign bi      = DW'(B_LSB) + DW'(plane);
    assign nxt_col = col + CW'(1);

    always_comb begin
        nxt_plane = plane + PW'(1);
        nxt_row   = row;
        if (plane == PW'(BITS - 1)) begin
            nxt_plane = '0;
            nxt_row   = row + ROW_BITS'(1);
        end
    end

    // Address_b is issued one cycle ahead so the 1-clk memory latency lines
    // up with the P1 (upper) and P2 (lower) captures.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SHIFT;
            phase       <= P0;
            col         <= '0;
            row         <= '0;
            plane       <= '0;
            upper       <= '0;
            Address_b   <= '0;
            panel_r1    <= 1'b0;
            panel_g1    <= 1'b0;
            panel_b1    <= 1'b0;
            panel_r2    <= 1'b0;
            panel_g2    <= 1'b0;
            panel_b2    <= 1'b0;
            panel_row   <= '0;
            panel_clk   <= 1'b0;
            panel_lat   <= 1'b0;
            panel_oe_n  <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            panel_lat   <= 1'b0;
            panel_oe_n  <= 1'b1;
            frame_start <= 1'b0;
            unique case (state)
                SHIFT: begin
                    phase <= phase + 2'd1;
                    unique case (phase)
                        P0: begin
                            Address_b   <= {1'b1, row, col};
                            frame_start <= (col == '0) && (row == '0)
                                           && (plane == '0);
                        end
                        P1: begin
                            upper <= DataOut_b;
                        end
                        P2: begin
                            panel_r1  <= upper[ri];
                            panel_g1  <= upper[gi];
                            panel_b1  <= upper[bi];
                            panel_r2  <= DataOut_b[ri];
                            panel_g2  <= DataOut_b[gi];
                            panel_b2  <= DataOut_b[bi];
                            panel_clk <= 1'b0;
                        end
                        P3: begin
                            panel_clk <= 1'b1;
                            col       <= nxt_col;
                            if (col == CW'(COLUMNS - 1)) begin
                                state <= LATCH;
                            end else begin
                                Address_b <= {1'b0, row, nxt_col};
                            end
                        end
                    endcase
                end
                LATCH: begin
                    panel_lat <= 1'b1;
                    panel_clk <= 1'b0;
                    panel_row <= row;
                    state     <= DISPLAY;
                end
                DISPLAY: begin
                    panel_oe_n <= !oe_active;
                    if (done) begin
                        plane     <= nxt_plane;
                        row       <= nxt_row;
                        Address_b <= {1'b0, nxt_row, CW'(0)};
                        state     <= SHIFT;
                    end
                end
                default: begin
                    state <= SHIFT;
                end
            endcase
        end
    end

endmodule
